// File: rtl/posit_dot_sched.sv
// posit_dot_sched: sequencer for the bit-serial posit MAC datapath.
// Streams (act, w) pairs into the MAC, chains each MAC result back as the next
// accumulator input and returns one fixed-point sum, exponent and sticky NaR per job.
// Optional build macro POSIT_SCHED_WATCHDOG_EN adds a WAIT-state watchdog that
// aborts a stalled job to OUT with res_nar set.
module posit_dot_sched #(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int TO_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic [3:0]           precision_cfg,
  input  logic [4:0]           exp_min_cfg,
  input  logic [ACC_WIDTH-1:0] acc_init,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [3:0]           in_w,
  output logic                 mac_valid,
  output logic                 mac_set,
  output logic [3:0]           mac_precision,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic [3:0]           mac_w,
  output logic [4:0]           mac_exp_min,
  output logic [ACC_WIDTH-1:0] mac_acc_in,
  input  logic                 mac_done,
  input  logic [ACC_WIDTH-1:0] mac_acc_out,
  input  logic [4:0]           mac_exp_out,
  input  logic                 mac_nar,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_acc,
  output logic [4:0]           res_exp,
  output logic                 res_nar,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_RUN, S_WAIT, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             prec_q, prec_d;
  logic [4:0]             exp_min_q, exp_min_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   elem_cnt_q, elem_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [4:0]             exp_q, exp_d;
  logic                   nar_q, nar_d;
  logic [ACT_WIDTH-1:0]   act_q, act_d;
  logic [3:0]             w_q, w_d;
  logic                   in_ready_q, in_ready_d;
  logic                   mac_valid_q, mac_valid_d;
  logic                   mac_set_q, mac_set_d;
  logic                   res_valid_q, res_valid_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   busy_q, busy_d;
  logic [LEN_WIDTH:0]     elem_next;
`ifdef POSIT_SCHED_WATCHDOG_EN
  logic [3:0]             wdog_q, wdog_d;
`else
  logic                   unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
`endif

  // Next-state, datapath and registered-output decode.
  // Handshake outputs are computed from state_d so each flop mirrors the state it belongs to.
  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    exp_min_d   = exp_min_q;
    len_d       = len_q;
    elem_cnt_d  = elem_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    exp_d       = exp_q;
    nar_d       = nar_q;
    act_d       = act_q;
    w_d         = w_q;
    cfg_err_d   = 1'b0;
    // one extra bit so vec_len = 2^LEN_WIDTH-1 terminates without wrap
    elem_next   = {1'b0, elem_cnt_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
`ifdef POSIT_SCHED_WATCHDOG_EN
    wdog_d      = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (precision_cfg >= 4'd2 && precision_cfg <= 4'd4) begin
            prec_d     = precision_cfg;
            exp_min_d  = exp_min_cfg;
            len_d      = vec_len;
            acc_d      = acc_init;
            exp_d      = exp_min_cfg;
            nar_d      = 1'b0;
            elem_cnt_d = '0;
            state_d    = S_CFG;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      S_CFG: state_d = (len_q == '0) ? S_OUT : S_LOAD;
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          act_d     = in_act;
          w_d       = in_w;
          bit_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == prec_q - 4'd1) begin
          state_d = S_WAIT;
`ifdef POSIT_SCHED_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mac_done) begin
          acc_d      = mac_acc_out;
          exp_d      = mac_exp_out;
          nar_d      = nar_q | mac_nar;
          elem_cnt_d = elem_next[LEN_WIDTH-1:0];
          state_d    = (elem_next == {1'b0, len_q}) ? S_OUT : S_LOAD;
        end
`ifdef POSIT_SCHED_WATCHDOG_EN
        else if (wdog_q == 4'(TO_CYCLES - 1)) begin
          nar_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          wdog_d  = wdog_q + 4'd1;
        end
`endif
      end
      S_OUT: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_LOAD);
    mac_valid_d = (state_d == S_RUN);
    mac_set_d   = (state_d == S_CFG);
    res_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prec_q      <= '0;
      exp_min_q   <= '0;
      len_q       <= '0;
      elem_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      nar_q       <= 1'b0;
      act_q       <= '0;
      w_q         <= '0;
      in_ready_q  <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_set_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POSIT_SCHED_WATCHDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      exp_min_q   <= exp_min_d;
      len_q       <= len_d;
      elem_cnt_q  <= elem_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      exp_q       <= exp_d;
      nar_q       <= nar_d;
      act_q       <= act_d;
      w_q         <= w_d;
      in_ready_q  <= in_ready_d;
      mac_valid_q <= mac_valid_d;
      mac_set_q   <= mac_set_d;
      res_valid_q <= res_valid_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
`ifdef POSIT_SCHED_WATCHDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign cfg_err       = cfg_err_q;
  assign in_ready      = in_ready_q;
  assign mac_valid     = mac_valid_q;
  assign mac_set       = mac_set_q;
  assign mac_precision = prec_q;
  assign mac_act       = act_q;
  assign mac_w         = w_q;
  assign mac_exp_min   = exp_min_q;
  assign mac_acc_in    = acc_q;
  assign res_valid     = res_valid_q;
  assign res_acc       = acc_q;
  assign res_exp       = exp_q;
  assign res_nar       = nar_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_posit_dot_sched.sv
// Randomized self-checking bench for posit_dot_sched with a behavioural MAC
// model and a fold-over-the-job reference for the final result.
module tb_posit_dot_sched;
  localparam int AW = 16;
  localparam int CW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, cfg_err, in_valid, in_ready;
  logic [LW-1:0] vec_len;
  logic [3:0]    precision_cfg, in_w, mac_precision, mac_w;
  logic [4:0]    exp_min_cfg, mac_exp_min, mac_exp_out, res_exp;
  logic [CW-1:0] acc_init, mac_acc_in, mac_acc_out, res_acc;
  logic [AW-1:0] in_act, mac_act;
  logic          mac_valid, mac_set, mac_done, mac_nar;
  logic          res_valid, res_ready, res_nar, busy;

  always #5 clk = ~clk;

  posit_dot_sched #(.ACT_WIDTH(AW), .ACC_WIDTH(CW), .LEN_WIDTH(LW), .TO_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .precision_cfg(precision_cfg),
    .exp_min_cfg(exp_min_cfg), .acc_init(acc_init), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
    .mac_valid(mac_valid), .mac_set(mac_set), .mac_precision(mac_precision),
    .mac_act(mac_act), .mac_w(mac_w), .mac_exp_min(mac_exp_min), .mac_acc_in(mac_acc_in),
    .mac_done(mac_done), .mac_acc_out(mac_acc_out), .mac_exp_out(mac_exp_out), .mac_nar(mac_nar),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_exp(res_exp),
    .res_nar(res_nar), .busy(busy)
  );

  int unsigned n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural MAC: one accumulate step and its exponent result.
  function automatic logic [31:0] mac_f(input logic [31:0] a, input logic [15:0] act, input logic [3:0] w);
    return a + ({16'b0, act} * ({28'b0, w} + 32'd1)) + 32'd1;
  endfunction
  function automatic logic [4:0] exp_f(input logic [15:0] act, input logic [3:0] w);
    return act[4:0] ^ {1'b0, w};
  endfunction

  logic [15:0] act_q[$];
  logic [3:0]  w_q[$];
  int          cur_prec, nar_idx, mac_elem;
  logic [31:0] last_acc_out;
  int unsigned mac_set_cnt, inrdy_bad, inrdy_cnt, hs_cnt, done_cnt, hold_bad, cfg_err_cnt;

  task automatic clear_counts();
    mac_set_cnt = 0; inrdy_bad = 0; inrdy_cnt = 0; hs_cnt = 0;
    done_cnt = 0; hold_bad = 0; cfg_err_cnt = 0; mac_elem = 0;
  endtask

  // MAC model plus protocol monitor, sampled on the falling edge.
  initial begin
    int unsigned vcnt, dly;
    bit pend;
    logic [15:0] run_act;
    logic [3:0]  run_w;
    vcnt = 0; dly = 0; pend = 0; run_act = '0; run_w = '0;
    mac_done = 0; mac_acc_out = '0; mac_exp_out = '0; mac_nar = 0;
    forever begin
      @(negedge clk);
      mac_done = 0;
      mac_nar  = 0;
      if (rst) begin
        vcnt = 0; pend = 0;
      end else begin
        if (mac_set) mac_set_cnt++;
        if (cfg_err) cfg_err_cnt++;
        if (in_ready) inrdy_cnt++;
        if (in_ready && (mac_valid || res_valid || mac_set)) inrdy_bad++;
        if (mac_valid) begin
          if (vcnt == 0) begin
            if (mac_elem < act_q.size()) begin
              check("mac_act", {16'b0, mac_act}, {16'b0, act_q[mac_elem]});
              check("mac_w", {28'b0, mac_w}, {28'b0, w_q[mac_elem]});
            end else check("extra_run", 1, 0);
            check("mac_acc_in", mac_acc_in, last_acc_out);
            run_act = mac_act; run_w = mac_w;
          end else if (mac_act !== run_act || mac_w !== run_w) hold_bad++;
          vcnt++;
        end else if (vcnt != 0) begin
          check("run_len", vcnt, cur_prec);
          vcnt = 0; pend = 1; dly = $urandom_range(0, 3);
        end else if (!pend && $urandom_range(0, 7) == 0) begin
          // stray completion outside WAIT: must be ignored
          mac_done = 1; mac_acc_out = $urandom; mac_exp_out = $urandom; mac_nar = 1;
        end
        if (pend) begin
          if (dly == 0) begin
            mac_done     = 1;
            mac_acc_out  = mac_f(mac_acc_in, mac_act, mac_w);
            mac_exp_out  = exp_f(mac_act, mac_w);
            mac_nar      = (mac_elem == nar_idx);
            last_acc_out = mac_acc_out;
            mac_elem++; done_cnt++; pend = 0;
          end else dly--;
        end
      end
    end
  end

  // Operand handshakes counted at the active edge.
  initial forever begin
    @(posedge clk);
    if (!rst && in_valid && in_ready) hs_cnt++;
  end

  task automatic fill(input int len);
    act_q.delete(); w_q.delete();
    for (int i = 0; i < len; i++) begin
      act_q.push_back(16'($urandom));
      w_q.push_back(4'($urandom));
    end
  endtask

  task automatic feed(input int len, input bit gappy);
    for (int i = 0; i < len; i++) begin
      int g, t;
      g = gappy ? 2 : int'($urandom_range(0, 2));
      repeat (g) begin
        start = 1'($urandom_range(0, 1)); precision_cfg = 4'($urandom);
        @(negedge clk);
      end
      start = 0;
      in_valid = 1; in_act = act_q[i]; in_w = w_q[i];
      t = 0;
      while (!in_ready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin check("in_ready_timeout", 0, 1); in_valid = 0; return; end
      @(negedge clk);
      in_valid = 0; in_act = 16'($urandom); in_w = 4'($urandom);
    end
  endtask

  task automatic run_job(input int len, input int prec, input logic [4:0] em, input logic [31:0] ai,
                         input int nidx, input int rr_dly, input bit gappy);
    logic [31:0] e_acc;
    logic [4:0]  e_exp;
    logic        e_nar;
    e_acc = ai; e_exp = em; e_nar = 0;
    for (int i = 0; i < len; i++) begin
      e_acc = mac_f(e_acc, act_q[i], w_q[i]);
      e_exp = exp_f(act_q[i], w_q[i]);
      if (i == nidx) e_nar = 1;
    end
    clear_counts();
    cur_prec = prec; nar_idx = nidx; last_acc_out = ai;
    @(negedge clk);
    start = 1; vec_len = LW'(len); precision_cfg = 4'(prec); exp_min_cfg = em; acc_init = ai;
    @(negedge clk);
    start = 0; vec_len = LW'($urandom); exp_min_cfg = 5'($urandom); acc_init = $urandom;
    fork
      feed(len, gappy);
      begin
        int t;
        bit stable;
        t = 0;
        while (!res_valid && t < 3000) begin @(negedge clk); t++; end
        check("res_seen", {31'b0, res_valid}, 1);
        check("res_acc", res_acc, e_acc);
        check("res_exp", {27'b0, res_exp}, {27'b0, e_exp});
        check("res_nar", {31'b0, res_nar}, {31'b0, e_nar});
        stable = 1;
        repeat (rr_dly) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_acc !== e_acc || res_exp !== e_exp || res_nar !== e_nar) stable = 0;
        end
        check("res_hold", {31'b0, stable}, 1);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        check("res_drop", {31'b0, res_valid}, 0);
        check("idle_busy", {31'b0, busy}, 0);
      end
    join
    check("mac_set_cnt", mac_set_cnt, 1);
    check("done_cnt", done_cnt, len);
    check("hs_cnt", hs_cnt, len);
    check("inrdy_bad", inrdy_bad, 0);
    check("hold_bad", hold_bad, 0);
    check("cfg_err_cnt", cfg_err_cnt, 0);
    if (len == 0) check("inrdy_len0", inrdy_cnt, 0);
  endtask

  task automatic cfg_bad(input int prec);
    clear_counts();
    @(negedge clk);
    start = 1; precision_cfg = 4'(prec); vec_len = 8'd2;
    @(negedge clk);
    start = 0;
    check("cfg_err_pulse", {31'b0, cfg_err}, 1);
    check("cfg_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("cfg_err_clear", {31'b0, cfg_err}, 0);
    check("cfg_no_set", mac_set_cnt, 0);
    check("cfg_stay_idle", {31'b0, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1; start = 0; vec_len = '0; precision_cfg = '0; exp_min_cfg = '0; acc_init = '0;
    in_valid = 0; in_act = '0; in_w = '0; res_ready = 0;
    act_q.delete(); w_q.delete();
    clear_counts(); cur_prec = 0; nar_idx = -1; last_acc_out = '0;
    repeat (3) @(negedge clk);
    check("rst_mac_valid", {31'b0, mac_valid}, 0);
    check("rst_mac_set", {31'b0, mac_set}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_res_valid", {31'b0, res_valid}, 0);
    check("rst_cfg_err", {31'b0, cfg_err}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_res_acc", res_acc, 0);
    rst = 0;

    // reset held 3 cycles in the middle of RUN
    fill(3); clear_counts(); cur_prec = 4; nar_idx = -1; last_acc_out = 32'h55;
    @(negedge clk);
    start = 1; vec_len = 8'd3; precision_cfg = 4'd4; exp_min_cfg = 5'd3; acc_init = 32'h55;
    @(negedge clk);
    start = 0; in_valid = 1; in_act = act_q[0]; in_w = w_q[0];
    t = 0;
    while (!mac_valid && t < 50) begin @(negedge clk); t++; end
    check("mid_run_reached", {31'b0, mac_valid}, 1);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort_mac_valid", {31'b0, mac_valid}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_res_valid", {31'b0, res_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // directed single element, precision 4, MAC returns 0x2000
    act_q.delete(); w_q.delete();
    act_q.push_back(16'h1FFF); w_q.push_back(4'h0);
    run_job(1, 4, 5'd7, 32'h0, -1, 1, 0);

    // three elements, precision 3, two-cycle operand gaps
    fill(3);
    run_job(3, 3, 5'd2, 32'h100, -1, 0, 1);

    // illegal precisions
    cfg_bad(5);
    cfg_bad(1);
    cfg_bad(0);

    // empty vector
    act_q.delete(); w_q.delete();
    run_job(0, 2, 5'd19, 32'h1234, -1, 2, 0);

    // NaR on element 2 of 4, consumer stalls 5 cycles
    fill(4);
    run_job(4, 3, 5'd9, 32'hDEAD_0000, 1, 5, 0);

    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      int len;
      len = int'($urandom_range(1, 6));
      fill(len);
      run_job(len, int'($urandom_range(2, 4)), 5'($urandom), $urandom,
              int'($urandom_range(0, 2 * len)) - len, int'($urandom_range(0, 4)), 0);
    end

    // longest vector must complete without counter wrap
    fill(255);
    run_job(255, 2, 5'd1, 32'h0, 200, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
